// File: rtl/if_stage_pkg.sv
// Shared types for the rv32imc pipeline front end.
//   pc_mux_t   : redirect select driven by execute (pc_offset = redirect)
//   if_stage_t : fetch -> decode payload {valid, pc, inst}
//   RESET_PC_DEFAULT : default program counter after reset
package rv32imc_types;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1eceb000;

    typedef enum logic [1:0] {
        pc_plus4  = 2'b00,
        pc_offset = 2'b01
    } pc_mux_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
    } if_stage_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO used by the fetch stage, both for the {pc, inst}
// queue and for the side FIFO that remembers the PC of each granted read.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   clear             empties the FIFO (wins over push/pop)
//   push, push_data   write one entry (ignored when full)
//   pop, pop_data     drop the head (ignored when empty); pop_data = head
//   count/empty/full  occupancy status
// DEPTH must be a power of two so the pointers wrap on their own.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr, rptr;
    logic             do_push, do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (clear) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage. Owns the PC, issues word-aligned imem reads under
// a credit rule (outstanding reads + queued words <= QUEUE_DEPTH), buffers
// returned words in order and presents the queue head to decode.
// A flush from execute redirects the PC, empties the queue and drops every
// response still in flight.
// Optional feature macro: IF_BYPASS_EN -- a non-dropped response arriving
// with the queue empty and decode ready goes straight to if_stage_reg in the
// same cycle instead of through the queue.
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   i_pc_mux, i_pc_offset        redirect select / target from execute
//   i_flush                      branch-taken flush from execute
//   if_stall                     decode cannot accept this cycle
//   o_imem_req/addr/rmask        read request
//   i_imem_gnt                   request accepted
//   i_imem_rvalid/rdata          in-order read response
//   if_stage_reg                 {valid, pc, inst} to decode
module if_stage
    import rv32imc_types::*;
#(
    parameter int          QUEUE_DEPTH = 4,
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  pc_mux_t     i_pc_mux,
    input  logic [31:0] i_pc_offset,
    input  logic        i_flush,
    input  logic        if_stall,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    output logic [3:0]  o_imem_rmask,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output if_stage_t   if_stage_reg
);

    localparam int CW = $clog2(QUEUE_DEPTH + 1);

    logic [31:0]   pc, target;
    logic [CW-1:0] inflight, drop_cnt, q_count, pcq_count;
    logic [CW:0]   credit_used;
    logic          gnt, keep_rsp, bypass;
    logic          q_push, q_pop, q_empty, q_full;
    logic [63:0]   q_head;
    logic [31:0]   pcq_head;
    logic          pcq_empty, pcq_full;
    logic          unused_status;

    // Bit 0 of a target is never meaningful for rv32imc.
    assign target = i_pc_offset & 32'hffff_fffe;

    assign credit_used  = {1'b0, inflight} + {1'b0, q_count};
    assign o_imem_req   = !i_flush && (credit_used < (CW+1)'(QUEUE_DEPTH));
    assign o_imem_addr  = {pc[31:2], 2'b00};
    assign o_imem_rmask = o_imem_req ? 4'hf : 4'h0;
    assign gnt          = i_imem_gnt && o_imem_req;

    // A response in the flush cycle belongs to the old path as well.
    assign keep_rsp = i_imem_rvalid && !i_flush && (drop_cnt == '0);

`ifdef IF_BYPASS_EN
    assign bypass = keep_rsp && q_empty && !if_stall;
`else
    assign bypass = 1'b0;
`endif

    assign q_push = keep_rsp && !bypass;
    assign q_pop  = !q_empty && !if_stall;

    // PC of every granted read, consumed by the matching kept response.
    // Dropped responses have no entry here: the flush cleared them.
    fetch_fifo #(.DEPTH(QUEUE_DEPTH), .WIDTH(32)) u_pc_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (i_flush),
        .push      (gnt),
        .push_data (pc),
        .pop       (keep_rsp),
        .pop_data  (pcq_head),
        .count     (pcq_count),
        .empty     (pcq_empty),
        .full      (pcq_full)
    );

    fetch_fifo #(.DEPTH(QUEUE_DEPTH), .WIDTH(64)) u_fetch_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (i_flush),
        .push      (q_push),
        .push_data ({pcq_head, i_imem_rdata}),
        .pop       (q_pop),
        .pop_data  (q_head),
        .count     (q_count),
        .empty     (q_empty),
        .full      (q_full)
    );

    // The credit rule keeps these status bits redundant.
    assign unused_status = ^{pcq_count, pcq_empty, pcq_full, q_full};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            inflight <= '0;
            drop_cnt <= '0;
        end else if (i_flush) begin
            // No grant can happen here since the request is masked.
            pc       <= target;
            inflight <= inflight - CW'(i_imem_rvalid);
            drop_cnt <= inflight - CW'(i_imem_rvalid);
        end else begin
            if (i_pc_mux == pc_offset) pc <= target;
            else if (gnt)              pc <= pc + 32'd4;
            if (gnt && !i_imem_rvalid)      inflight <= inflight + 1'b1;
            else if (!gnt && i_imem_rvalid) inflight <= inflight - 1'b1;
            if (i_imem_rvalid && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
        end
    end

    always_comb begin
        if_stage_reg = '0;
        if (bypass) begin
            if_stage_reg.valid = 1'b1;
            if_stage_reg.pc    = pcq_head;
            if_stage_reg.inst  = i_imem_rdata;
        end else if (!q_empty) begin
            if_stage_reg.valid = 1'b1;
            if_stage_reg.pc    = q_head[63:32];
            if_stage_reg.inst  = q_head[31:0];
        end
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction fetch stage of the rv32imc pipeline, and the consuming end of the execute stage's redirect interface (`pc_mux`, `pc_offset`, `flush`). It owns the program counter and issues word-aligned instruction-memory reads. Returned words are buffered in an in-order fetch queue, and the queue head is presented to decode through `if_stage_reg`. On a taken branch or jump it redirects the PC, empties the queue and discards responses that are still in flight.

## Interface
Parameters:
- `QUEUE_DEPTH`, default 4: fetch queue entries; a power of two, at least 2. It also bounds the number of outstanding reads.
- `RESET_PC`, default 32'h1eceb000: PC value after reset.

Ports:
- `clk`  in  1  clock; everything is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_pc_mux`  in  `pc_mux_t`  redirect select from execute; `pc_offset` means redirect.
- `i_pc_offset`  in  32  redirect target from execute.
- `i_flush`  in  1  branch-taken flush from execute; asserted together with `i_pc_mux==pc_offset`.
- `if_stall`  in  1  decode cannot accept this cycle.
- `o_imem_req`  out  1  read request valid.
- `o_imem_addr`  out  32  `{pc[31:2],2'b00}`.
- `o_imem_rmask`  out  4  4'hf while `o_imem_req` is high, otherwise 0.
- `i_imem_gnt`  in  1  request accepted this cycle.
- `i_imem_rvalid`  in  1  read data valid. Responses return in order, at least 1 cycle after grant.
- `i_imem_rdata`  in  32  read data.
- `if_stage_reg`  out  `if_stage_t`  `{valid, pc, inst}`.

## Operation
- **PC register.** Reset value is `RESET_PC`. It advances by 4 on each granted request.
- **Request issue.** `o_imem_req` = `!i_flush && (inflight + count < QUEUE_DEPTH)`.
  - `inflight` = granted requests not yet answered. It includes responses marked for drop.
  - `count` = queue occupancy.
  - This credit rule means a returned word always has a queue slot, so the queue never overflows.
- **Response handling.**
  - If `drop_cnt != 0`, the response decrements `drop_cnt` and is discarded.
  - Otherwise `{pc_of_request, rdata}` is pushed into the queue. The request PC is held in a side FIFO of depth `QUEUE_DEPTH`.
- **Output.** `if_stage_reg.valid` = queue not empty. `pc` and `inst` come from the queue head. The head pops when `valid && !if_stall`.
- **Redirect.** `i_flush` has priority over every other event in the same cycle:
  - `pc <= i_pc_offset`;
  - the queue and the PC side FIFO are cleared;
  - `drop_cnt <= inflight - i_imem_rvalid`, and a response arriving in the flush cycle is also dropped;
  - no request is issued that cycle;
  - a grant in that cycle cannot occur, because `o_imem_req` is low.
- **Flush during stall.** The flush still clears the queue, and `valid` is 0 the next cycle.
- **Alignment.** Full `pc` (including bit 1) is carried with each entry. Realigning compressed instructions is decode's job. `i_pc_offset[0]` is ignored, i.e. treated as 0.
- **Counter widths.** `inflight`, `count` and `drop_cnt` are `$clog2(QUEUE_DEPTH+1)` bits. Queue pointers are `$clog2(QUEUE_DEPTH)` bits and wrap naturally.
- **Reset values.**
  - `pc`=`RESET_PC`; `inflight`, `count`, `drop_cnt` and pointers = 0.
  - `if_stage_reg` = all zeros.
  - `o_imem_req` goes high in the first cycle after `rst_n` is released.
  - Reset asserted mid-operation abandons outstanding reads. The memory side is reset by the same `rst_n`.

## Timing
- The first request is in the first cycle after reset release.
- Back-to-back grants are allowed, one per cycle.
- Default latency: `i_imem_rvalid` in cycle N gives `valid` in cycle N+1.
- **Redirect latency.** With `i_flush` in cycle N:
  - `o_imem_addr` equals the target in cycle N+1;
  - the first new instruction appears in cycle N+1+L+1, where L is the memory latency.
- There is no combinational path from `i_flush` to `if_stage_reg`. There is a path from `i_flush` to `o_imem_req`.
- **Simultaneous events in one cycle.**
  - Push and pop in the same cycle leave `count` unchanged.
  - Grant and response in the same cycle leave `inflight` unchanged.

## Configuration
- `IF_BYPASS_EN` defined: a response that is not dropped, arriving while the queue is empty and `!if_stall`, drives `if_stage_reg` combinationally in the same cycle and is not written to the queue. Latency is 0 cycles.
- `IF_BYPASS_EN` undefined: every response goes through the queue. Latency is 1 cycle, and there is no combinational path from imem to decode.

## Structure
- In package `rv32imc_types`:
  - the `if_stage_t` struct;
  - a `RESET_PC` default constant;
  - the existing `pc_mux_t`, reused unchanged.
- Sub-module `fetch_fifo`:
  - parameterised by `DEPTH` and width;
  - push/pop/clear ports, plus `count`, `empty` and `full` outputs;
  - instantiated once for `{pc, inst}` entries.
  - The request-PC side FIFO reuses the same `fetch_fifo`.

## Test plan
- **Reset and streaming.** Hold reset, release, 1-cycle memory, no stall → addresses 1eceb000, 1eceb004, 1eceb008…; `valid` from cycle 3, one instruction per cycle in order.
- **Back-pressure.** `if_stall` held high for 10 cycles with a 1-cycle memory → exactly `QUEUE_DEPTH` requests are granted, then `o_imem_req`=0. On release, entries drain in PC order with no loss.
- **Redirect with reads in flight.** 3-cycle memory, flush to 0x1eceb100 with 2 reads in flight → those 2 responses are discarded, and the next delivered `pc`=0x1eceb100.
- **Flush edge cases.**
  - Flush in the same cycle as `i_imem_rvalid` → that word is never delivered.
  - Flush while stalled with a full queue → `valid`=0 the next cycle.
- **Odd target and reset mid-burst.**
  - Redirect target 0x1eceb102 → `o_imem_addr`=0x1eceb100, and the delivered `pc`=0x1eceb102.
  - Assert `rst_n` low mid-burst → all outputs return to reset values immediately (asynchronous reset).
- **Bypass, run with and without `IF_BYPASS_EN`.** Empty queue, `rvalid` in cycle N → `valid` in cycle N with the macro defined, and in cycle N+1 without it.
